// File: rtl/rr_mux_select_arbiter.sv
// Round-robin arbiter driving the 2-bit select of a downstream 4:1 mux.
// One grant at a time, with an idle cycle between grants and a hold timeout.
module rr_mux_select_arbiter #(
  parameter int HOLD_MAX = 8
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [3:0] R,
  input  logic       Done,
  output logic [3:0] G,
  output logic [1:0] S,
  output logic       Valid,
  output logic       Timeout
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [7:0] CNT_LAST = 8'(HOLD_MAX - 1);

  state_t     state;
  logic [1:0] ptr;
  logic [7:0] cnt;
  logic [1:0] win_idx;
  logic       rel_any;
  logic       rel_forced;

  // First requester found when scanning upward from the priority pointer.
  function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] start);
    logic [1:0] idx;
    logic       found;
    rr_pick = start;
    found   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idx = start + 2'(i);
      if (!found && req[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  always_comb begin
    win_idx    = rr_pick(R, ptr);
    rel_forced = 1'b0;
    rel_any    = 1'b0;
    if (Done || !R[S]) begin
      rel_any = 1'b1;
    end else if (cnt == CNT_LAST) begin
      rel_any    = 1'b1;
      rel_forced = 1'b1;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state   <= IDLE;
      ptr     <= 2'd0;
      cnt     <= 8'd0;
      G       <= 4'b0000;
      S       <= 2'd0;
      Valid   <= 1'b0;
      Timeout <= 1'b0;
    end else begin
      Timeout <= 1'b0;
      case (state)
        IDLE: begin
          // S is left alone while idle so the mux select never toggles.
          if (|R) begin
            G     <= 4'b0001 << win_idx;
            S     <= win_idx;
            Valid <= 1'b1;
            cnt   <= 8'd0;
            state <= BUSY;
          end else begin
            G     <= 4'b0000;
            Valid <= 1'b0;
          end
        end
        BUSY: begin
          if (rel_any) begin
            G       <= 4'b0000;
            Valid   <= 1'b0;
            ptr     <= S + 2'd1;
            Timeout <= rel_forced;
            state   <= IDLE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: begin
          state <= IDLE;
          G     <= 4'b0000;
          Valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_mux_select_arbiter.sv
// Bench for rr_mux_select_arbiter: directed vector table, corner sequences,
// and randomized traffic against a behavioural owner/priority model.
module tb_rr_mux_select_arbiter;

  localparam int HOLD_MAX = 8;

  logic       Clock;
  logic       Reset;
  logic [3:0] R;
  logic       Done;
  logic [3:0] G;
  logic [1:0] S;
  logic       Valid;
  logic       Timeout;

  rr_mux_select_arbiter #(.HOLD_MAX(HOLD_MAX)) dut (
    .Clock  (Clock),
    .Reset  (Reset),
    .R      (R),
    .Done   (Done),
    .G      (G),
    .S      (S),
    .Valid  (Valid),
    .Timeout(Timeout)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  int n_total = 0;
  int n_pass  = 0;

  // Reference model: who owns the mux, how many cycles it has held it,
  // who has top priority next, and what select value is showing.
  int         m_owner = -1;
  int         m_held  = 0;
  int         m_ptr   = 0;
  logic [1:0] m_sel   = 2'd0;
  logic       m_to    = 1'b0;

  typedef struct {
    logic       rst;
    logic [3:0] r;
    logic       done;
    logic [3:0] g;
    logic [1:0] s;
    logic       v;
    logic       to;
  } vec_t;

  vec_t vecs[25];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    else
      n_pass++;
  endtask

  task automatic model_step(input logic rst, input logic [3:0] r, input logic d);
    int k;
    logic rel;
    rel = 1'b0;
    if (rst) begin
      m_owner = -1; m_held = 0; m_ptr = 0; m_sel = 2'd0; m_to = 1'b0;
    end else if (m_owner < 0) begin
      m_to = 1'b0;
      for (int i = 0; i < 4; i++) begin
        k = (m_ptr + i) % 4;
        if (m_owner < 0 && r[k]) begin
          m_owner = k;
          m_sel   = 2'(k);
          m_held  = 1;
        end
      end
    end else begin
      m_to = 1'b0;
      if (d || !r[m_owner]) rel = 1'b1;
      else if (m_held == HOLD_MAX) begin
        rel  = 1'b1;
        m_to = 1'b1;
      end else m_held++;
      if (rel) begin
        m_ptr   = (m_owner + 1) % 4;
        m_owner = -1;
      end
    end
  endtask

  function automatic logic [7:0] model_out();
    logic [3:0] g;
    g = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
    return {g, m_sel, (m_owner >= 0), m_to};
  endfunction

  // Apply inputs, clock once, advance the model, compare just after the edge.
  task automatic step(input logic rst, input logic [3:0] r, input logic d, input string name);
    Reset = rst; R = r; Done = d;
    @(posedge Clock);
    model_step(rst, r, d);
    #1;
    check(name, {G, S, Valid, Timeout}, model_out());
  endtask

  initial begin
    int nvalid;
    int npulse;
    logic [3:0] rr;
    logic rs, dd;

    Reset = 1'b1; R = 4'b0000; Done = 1'b0;

    //        rst   r        done  g        s     v     to
    vecs[0]  = '{1'b1, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 4'b0100, 1'b1, 4'b0000, 2'd2, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 4'b1111, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 4'b1111, 1'b1, 4'b0000, 2'd3, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 4'b1111, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 4'b1111, 1'b1, 4'b0000, 2'd1, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 4'b1111, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 4'b1111, 1'b1, 4'b0000, 2'd2, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 4'b1111, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 4'b1111, 1'b1, 4'b0000, 2'd3, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0};
    vecs[14] = '{1'b0, 4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0};
    vecs[15] = '{1'b0, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0};
    vecs[16] = '{1'b0, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0};
    vecs[17] = '{1'b0, 4'b0000, 1'b0, 4'b0000, 2'd2, 1'b0, 1'b0};
    vecs[18] = '{1'b0, 4'b0101, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0};
    vecs[19] = '{1'b0, 4'b0101, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0};
    vecs[20] = '{1'b0, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0};
    vecs[21] = '{1'b0, 4'b1000, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0};
    vecs[22] = '{1'b1, 4'b1000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0};
    vecs[23] = '{1'b0, 4'b1010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0};
    vecs[24] = '{1'b0, 4'b1010, 1'b1, 4'b0000, 2'd1, 1'b0, 1'b0};

    for (int i = 0; i < 25; i++) begin
      Reset = vecs[i].rst; R = vecs[i].r; Done = vecs[i].done;
      @(posedge Clock);
      model_step(vecs[i].rst, vecs[i].r, vecs[i].done);
      #1;
      check($sformatf("vec%0d", i), {G, S, Valid, Timeout},
            {vecs[i].g, vecs[i].s, vecs[i].v, vecs[i].to});
    end

    // Hold timeout with a lone requester, then regrant after one idle cycle.
    step(1'b1, 4'b0000, 1'b0, "to_reset");
    nvalid = 0; npulse = 0;
    for (int i = 0; i < HOLD_MAX + 1; i++) begin
      step(1'b0, 4'b0001, 1'b0, "to_seq");
      if (Valid) nvalid++;
      if (Timeout) npulse++;
    end
    check("to_hold_len", nvalid, HOLD_MAX);
    check("to_pulse_cnt", npulse, 1);
    check("to_pulse_now", Timeout, 1'b1);
    step(1'b0, 4'b0001, 1'b0, "to_regrant");
    check("to_regrant_g", G, 4'b0001);
    check("to_pulse_clear", Timeout, 1'b0);

    // Done arriving on the very cycle the hold limit is reached wins.
    step(1'b1, 4'b0000, 1'b0, "dt_reset");
    step(1'b0, 4'b0010, 1'b0, "dt_grant");
    for (int i = 0; i < HOLD_MAX - 1; i++) step(1'b0, 4'b0010, 1'b0, "dt_hold");
    check("dt_still_valid", Valid, 1'b1);
    step(1'b0, 4'b0010, 1'b1, "dt_release");
    check("dt_no_timeout", Timeout, 1'b0);
    check("dt_valid_low", Valid, 1'b0);

    // Randomized traffic.
    rr = 4'b0000;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) rr = 4'($urandom_range(0, 15));
      dd = ($urandom_range(0, 11) == 0);
      rs = ($urandom_range(0, 299) == 0);
      step(rs, rr, dd, "rand");
      check("rand_onehot0", $onehot0(G), 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
